// File: rtl/enc_frame_sched.sv
// enc_frame_sched: shares one 8b/10b frame encoder between NREQ byte-stream
// requesters using round-robin arbitration. Each frame is sent to the encoder
// as four K28.1 preamble words, the payload bytes, and a K23.7 end marker,
// followed by a quiet window while the encoder emits its own trailer.
// Build option: define SCHED_PRIO0_EN to make requester 0 win every
// arbitration it takes part in. The remaining requesters still rotate.
//
// state | meaning
// IDLE  | no frame in flight; arbitrate over src_valid
// PRE   | emitting preamble words 2..4 (K28.1)
// DATA  | forwarding the owner's payload bytes
// DRAIN | frame truncated at MAX_LEN; discarding bytes up to src_last
// EOP   | emitting the K23.7 end marker
// TRAIL | quiet window while the encoder appends CRC/K28.5

module enc_frame_sched #(
  parameter int NREQ      = 4,
  parameter int MAX_LEN   = 64,
  parameter int TRAIL_CYC = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   src_valid,
  input  logic [8*NREQ-1:0] src_data,
  input  logic [NREQ-1:0]   src_last,
  output logic [NREQ-1:0]   src_ready,
  output logic [NREQ-1:0]   gnt,
  output logic              enc_pushin,
  output logic [8:0]        enc_datain,
  output logic              enc_startin,
  output logic              err_overlen,
  output logic              busy
);

  localparam int PW = $clog2(NREQ);
  localparam int TW = (TRAIL_CYC > 1) ? $clog2(TRAIL_CYC) : 1;
  localparam logic [8:0]    K28_1      = 9'h13C;
  localparam logic [8:0]    K23_7      = 9'h1F7;
  localparam logic [7:0]    MAX_LEN_B  = 8'(MAX_LEN);
  localparam logic [TW-1:0] TRAIL_LOAD = TW'(TRAIL_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_DATA, S_DRAIN, S_EOP, S_TRAIL
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [7:0]        len_q, len_d;
  logic [1:0]        pre_q, pre_d;
  logic [TW-1:0]     trail_q, trail_d;
  logic              push_q, push_d;
  logic [8:0]        data_q, data_d;
  logic              start_q, start_d;
  logic              err_q, err_d;

  logic [PW:0]       rot_sh;
  logic [2*NREQ-1:0] rot_dbl;
  logic [PW-1:0]     win_off;
  logic [PW:0]       win_sum;
  logic [PW-1:0]     win_idx;
  logic              win_found;

  logic [7:0]        own_byte;
  logic              own_valid;
  logic              own_last;

  // Rotate requests so the search starts at rr_q+1, then map the hit back.
  always_comb begin
    rot_sh    = {1'b0, rr_q} + (PW+1)'(1);
    rot_dbl   = {src_valid, src_valid} >> rot_sh;
    win_off   = '0;
    win_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && rot_dbl[k]) begin
        win_found = 1'b1;
        win_off   = PW'(k);
      end
    end
    win_sum = {1'b0, rr_q} + {1'b0, win_off} + (PW+1)'(1);
    if (win_sum >= (PW+1)'(NREQ)) begin
      win_sum = win_sum - (PW+1)'(NREQ);
    end
    win_idx = win_sum[PW-1:0];
`ifdef SCHED_PRIO0_EN
    if (src_valid[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`else
`endif
  end

  // Select the current owner's byte lane via the one-hot grant.
  always_comb begin
    own_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        own_byte = src_data[8*i +: 8];
      end
    end
  end

  assign own_valid = |(src_valid & gnt_q);
  assign own_last  = |(src_last & gnt_q);

  // Next-state, next-output and combinational ready logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    len_d     = len_q;
    pre_d     = pre_q;
    trail_d   = trail_q;
    push_d    = 1'b0;
    data_d    = data_q;
    start_d   = 1'b0;
    err_d     = 1'b0;
    src_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d   = NREQ'(1) << win_idx;
          rr_d    = win_idx;
          push_d  = 1'b1;
          data_d  = K28_1;
          start_d = 1'b1;
          pre_d   = 2'd2;
          len_d   = '0;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        push_d = 1'b1;
        data_d = K28_1;
        if (pre_q == 2'd0) begin
          state_d = S_DATA;
        end else begin
          pre_d = pre_q - 2'd1;
        end
      end
      S_DATA: begin
        src_ready = gnt_q;
        if (own_valid) begin
          push_d = 1'b1;
          data_d = {1'b0, own_byte};
          len_d  = len_q + 8'd1;
          if (own_last) begin
            state_d = S_EOP;
          end else if (len_q + 8'd1 == MAX_LEN_B) begin
            err_d   = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        src_ready = gnt_q;
        if (own_valid && own_last) begin
          state_d = S_EOP;
        end
      end
      S_EOP: begin
        push_d  = 1'b1;
        data_d  = K23_7;
        trail_d = TRAIL_LOAD;
        state_d = S_TRAIL;
      end
      S_TRAIL: begin
        if (trail_q == '0) begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          trail_d = trail_q - TW'(1);
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      rr_q    <= PW'(NREQ - 1);
      len_q   <= '0;
      pre_q   <= '0;
      trail_q <= '0;
      push_q  <= 1'b0;
      data_q  <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      len_q   <= len_d;
      pre_q   <= pre_d;
      trail_q <= trail_d;
      push_q  <= push_d;
      data_q  <= data_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  assign gnt         = gnt_q;
  assign enc_pushin  = push_q;
  assign enc_datain  = data_q;
  assign enc_startin = start_q;
  assign err_overlen = err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_enc_frame_sched.sv
// Bench for enc_frame_sched: directed frames from the test plan followed by
// randomized frames, checked against a frame-level reference model.
module tb_enc_frame_sched;
  localparam int NREQ      = 4;
  localparam int MAX_LEN   = 4;
  localparam int TRAIL_CYC = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   src_valid = '0;
  logic [8*NREQ-1:0] src_data = '0;
  logic [NREQ-1:0]   src_last = '0;
  logic [NREQ-1:0]   src_ready;
  logic [NREQ-1:0]   gnt;
  logic              enc_pushin;
  logic [8:0]        enc_datain;
  logic              enc_startin;
  logic              err_overlen;
  logic              busy;

  enc_frame_sched #(.NREQ(NREQ), .MAX_LEN(MAX_LEN), .TRAIL_CYC(TRAIL_CYC)) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_data(src_data),
    .src_last(src_last), .src_ready(src_ready), .gnt(gnt),
    .enc_pushin(enc_pushin), .enc_datain(enc_datain), .enc_startin(enc_startin),
    .err_overlen(err_overlen), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, expected finish before 300000");
    $fatal(1, "watchdog");
  end

  // per-requester byte queues, entries are {last, byte}
  logic [8:0]      srcq [NREQ][$];
  int              stall_cnt [NREQ];
  int              n_cmp = 0;
  int              n_fail = 0;
  int              cyc = 0;

  // reference model state
  int              model_rr = NREQ - 1;
  bit              in_frame = 1'b0;
  int              owner = 0;
  int              end_cyc = -1000;
  logic [9:0]      exp_q[$];
  bit              exp_err = 1'b0;
  int              exp_gap = 0;
  int              err_seen = 0;
  int              gap = 0;
  int              word_idx = 0;
  logic [NREQ-1:0] prev_valid = '0;
  bit              prev_busy = 1'b0;
  logic [NREQ-1:0] exp_gnt = '0;
  bit              gap_check = 1'b1;
  int              extra_gap = 0;
  bit              rand_stall = 1'b0;
  int              stall_at_word = -1;

  logic [9:0]      last_words[$];
  int              owner_log[$];
  int              last_gap = 0;
  int              last_err = 0;
  int              last_end = 0;
  int              busy_fall_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int rr);
`ifdef SCHED_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (rr + k) % NREQ;
      if (v[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int w);
    logic [NREQ-1:0] r;
    r = '0;
    r[w] = 1'b1;
    return r;
  endfunction

  task automatic push_byte(input int r, input logic [7:0] b, input bit last);
    srcq[r].push_back({last, b});
  endtask

  // Expected encoder words for the head frame of requester w.
  task automatic start_frame(input int w);
    int len;
    len = 0;
    exp_q.delete();
    exp_q.push_back({1'b1, 9'h13C});
    for (int k = 0; k < 3; k++) exp_q.push_back({1'b0, 9'h13C});
    for (int k = 0; k < srcq[w].size(); k++) begin
      len++;
      if (len <= MAX_LEN) exp_q.push_back({2'b00, srcq[w][k][7:0]});
      if (srcq[w][k][8]) break;
    end
    exp_q.push_back({1'b0, 9'h1F7});
    exp_err = (len > MAX_LEN);
    exp_gap = ((len > MAX_LEN) ? len - MAX_LEN : 0) + extra_gap;
  endtask

  task automatic drive();
    logic [NREQ-1:0]   v, l;
    logic [8*NREQ-1:0] d;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rand_stall && stall_cnt[i] == 0 && $urandom_range(0, 5) == 0)
        stall_cnt[i] = $urandom_range(1, 2);
      if (srcq[i].size() > 0 && stall_cnt[i] == 0) begin
        v[i] = 1'b1;
        d[8*i +: 8] = srcq[i][0][7:0];
        l[i] = srcq[i][0][8];
      end else begin
        d[8*i +: 8] = 8'($urandom);
        l[i] = 1'($urandom_range(0, 1));
      end
      if (stall_cnt[i] > 0) stall_cnt[i]--;
    end
    src_valid = v;
    src_data  = d;
    src_last  = l;
    prev_valid = v;
  endtask

  task automatic sample();
    bit         exp_start;
    bit         exp_busy;
    logic [9:0] w;
    if (err_overlen === 1'b1) err_seen++;
    exp_start = !prev_busy && (prev_valid != '0);
    chk("startin", 32'(enc_startin), 32'(exp_start));
    if (exp_start) begin
      owner = pick(prev_valid, model_rr);
      model_rr = owner;
      owner_log.push_back(owner);
      start_frame(owner);
      in_frame = 1'b1;
      err_seen = 0;
      gap = 0;
      word_idx = 0;
      last_words.delete();
    end
    if (enc_pushin === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("push_outside_frame", 32'(enc_pushin), 32'(0));
      end else begin
        w = exp_q.pop_front();
        chk("enc_word", 32'({enc_startin, enc_datain}), 32'(w));
        last_words.push_back({enc_startin, enc_datain});
        word_idx++;
        if (exp_q.size() == 0 && in_frame) begin
          in_frame = 1'b0;
          end_cyc = cyc;
          last_end = cyc;
          last_gap = gap;
          last_err = err_seen;
          chk("overlen_pulses", 32'(err_seen), 32'(exp_err));
          if (gap_check) chk("bubbles", 32'(gap), 32'(exp_gap));
        end
      end
    end else if (in_frame) begin
      gap++;
    end
    if (in_frame && enc_pushin === 1'b1 && word_idx == stall_at_word) begin
      stall_cnt[owner] = 3;
      stall_at_word = -1;
    end
    exp_busy = in_frame || (cyc < end_cyc + TRAIL_CYC);
    exp_gnt = exp_busy ? oh(owner) : '0;
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    if (prev_busy && !exp_busy) busy_fall_cyc = cyc;
    prev_busy = exp_busy;
  endtask

  task automatic cycle();
    logic [NREQ-1:0] acc;
    @(negedge clk);
    acc = src_valid & src_ready;
    chk("ready_owner_only", 32'(src_ready & ~exp_gnt), 32'(0));
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++)
      if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    sample();
    drive();
  endtask

  function automatic bit pending();
    bit p;
    p = in_frame;
    for (int i = 0; i < NREQ; i++) if (srcq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while ((pending() || prev_busy) && n < budget);
    chk("run_bounded", 32'(pending() || prev_busy), 32'(0));
  endtask

  initial begin
    int base;
    int nb;
    logic [9:0] t1 [7];
    t1[0] = 10'h33C; t1[1] = 10'h13C; t1[2] = 10'h13C; t1[3] = 10'h13C;
    t1[4] = 10'h0A5; t1[5] = 10'h05A; t1[6] = 10'h1F7;
    for (int i = 0; i < NREQ; i++) stall_cnt[i] = 0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_pushin", 32'(enc_pushin), 32'(0));
    chk("rst_datain", 32'(enc_datain), 32'(0));
    chk("rst_startin", 32'(enc_startin), 32'(0));
    chk("rst_err", 32'(err_overlen), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_ready", 32'(src_ready), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // requester 0: A5, 5A(last)
    push_byte(0, 8'hA5, 1'b0);
    push_byte(0, 8'h5A, 1'b1);
    run_idle(200);
    chk("t1_words", 32'(last_words.size()), 32'(7));
    for (int i = 0; i < 7; i++)
      if (i < last_words.size()) chk("t1_word", 32'(last_words[i]), 32'(t1[i]));
    chk("t1_owner", 32'(owner_log[owner_log.size()-1]), 32'(0));
    chk("t1_trailer_len", 32'(busy_fall_cyc - last_end), 32'(TRAIL_CYC));

    // rotation and wrap: 1, then {1,2,3} together -> 2,3,1
    push_byte(1, 8'h10, 1'b1);
    run_idle(200);
    base = owner_log.size();
    push_byte(1, 8'h21, 1'b1);
    push_byte(2, 8'h32, 1'b0);
    push_byte(2, 8'h33, 1'b1);
    push_byte(3, 8'h44, 1'b1);
    run_idle(300);
    chk("rr_frames", 32'(owner_log.size() - base), 32'(3));
    if (owner_log.size() >= base + 3) begin
      chk("rr_first", 32'(owner_log[base]), 32'(2));
      chk("rr_second", 32'(owner_log[base+1]), 32'(3));
      chk("rr_wrap", 32'(owner_log[base+2]), 32'(1));
    end

    // owner stalls for 3 cycles after its second payload byte
    extra_gap = 3;
    stall_at_word = 6;
    for (int i = 0; i < 4; i++) push_byte(2, 8'h61 + 8'(i), i == 3);
    run_idle(200);
    extra_gap = 0;
    chk("stall_gap", 32'(last_gap), 32'(3));
    chk("stall_words", 32'(last_words.size()), 32'(9));
    for (int i = 0; i < 4; i++)
      if (4 + i < last_words.size()) chk("stall_order", 32'(last_words[4+i]), 32'(10'h061 + 10'(i)));

    // 7 bytes against MAX_LEN=4
    for (int i = 0; i < 7; i++) push_byte(3, 8'h81 + 8'(i), i == 6);
    run_idle(200);
    chk("ovl_err", 32'(last_err), 32'(1));
    chk("ovl_words", 32'(last_words.size()), 32'(9));
    if (last_words.size() == 9) begin
      chk("ovl_last_payload", 32'(last_words[7]), 32'(10'h084));
      chk("ovl_marker", 32'(last_words[8]), 32'(10'h1F7));
    end
    chk("ovl_drain", 32'(last_gap), 32'(3));

    // priority option: rr at 0, requesters 0 and 3 compete
    push_byte(0, 8'h01, 1'b1);
    run_idle(200);
    base = owner_log.size();
    push_byte(0, 8'h02, 1'b1);
    push_byte(3, 8'h03, 1'b1);
    run_idle(300);
`ifdef SCHED_PRIO0_EN
    chk("prio_winner", 32'(owner_log[base]), 32'(0));
`else
    chk("prio_winner", 32'(owner_log[base]), 32'(3));
`endif

    // reset during DATA
    push_byte(1, 8'h11, 1'b0);
    push_byte(1, 8'h22, 1'b0);
    push_byte(1, 8'h33, 1'b1);
    nb = 0;
    do begin
      cycle();
      nb++;
    end while (!(in_frame && word_idx >= 5) && nb < 50);
    chk("reach_data", 32'(in_frame && word_idx >= 5), 32'(1));
    reset = 1'b1;
    #2;
    chk("mid_rst_pushin", 32'(enc_pushin), 32'(0));
    chk("mid_rst_gnt", 32'(gnt), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_err", 32'(err_overlen), 32'(0));
    exp_q.delete();
    in_frame = 1'b0;
    end_cyc = -1000;
    model_rr = NREQ - 1;
    prev_busy = 1'b0;
    exp_gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      srcq[i].delete();
      stall_cnt[i] = 0;
    end
    src_valid = '0;
    prev_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    base = owner_log.size();
    push_byte(0, 8'h55, 1'b1);
    push_byte(2, 8'h77, 1'b1);
    run_idle(300);
    chk("post_rst_owner", 32'(owner_log[base]), 32'(0));
    chk("post_rst_words", 32'(last_words.size()), 32'(6));
    if (last_words.size() > 0) chk("post_rst_start", 32'(last_words[0]), 32'(10'h33C));

    // randomized frames with random source stalls
    gap_check = 1'b0;
    rand_stall = 1'b1;
    for (int it = 0; it < 30; it++) begin
      int any;
      any = 0;
      for (int r = 0; r < NREQ; r++) begin
        if ($urandom_range(0, 1) == 1 || (r == NREQ - 1 && any == 0)) begin
          int len;
          len = $urandom_range(1, 7);
          for (int k = 0; k < len; k++) push_byte(r, 8'($urandom), k == len - 1);
          any++;
        end
      end
      run_idle(600);
    end
    rand_stall = 1'b0;
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
